// File: rtl/wishbone_arbiter.sv
// wishbone_arbiter
//   Round-robin arbiter sharing one Wishbone slave port among NUM_MASTERS
//   masters. A master keeps the bus for its whole CYC tenure (bursts, STB
//   gaps included). A watchdog ends a strobe the slave never answers,
//   returning ERR to the owner for one cycle.
//
// Ports
//   clk_i, rst_i          clock (rising edge), async active-high reset
//   m_cyc_i/stb_i/we_i    per-master controls, one bit per master
//   m_addr_i/data_i/...   per-master packed buses, master k at slice k
//   m_data_o              read data, shared by all masters (= s_data_i)
//   m_ack_o/m_err_o       per-master responses, only the owner's bit moves
//   s_*_o                 slave-side request, muxed from the owner
//   s_data_i/ack_i/err_i  slave response
//   grant_o               registered one-hot grant
//   busy_o                bus is owned (state != IDLE)
module wishbone_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int SEL_WIDTH   = DATA_WIDTH / 8,
    parameter int TIMEOUT     = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_i,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
    input  logic [NUM_MASTERS*3-1:0]          m_cti_i,
    output logic [DATA_WIDTH-1:0]             m_data_o,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic                              s_we_o,
    output logic [ADDR_WIDTH-1:0]             s_addr_o,
    output logic [DATA_WIDTH-1:0]             s_data_o,
    output logic [SEL_WIDTH-1:0]              s_sel_o,
    output logic [2:0]                        s_cti_o,
    input  logic [DATA_WIDTH-1:0]             s_data_i,
    input  logic                              s_ack_i,
    input  logic                              s_err_i,
    output logic [NUM_MASTERS-1:0]            grant_o,
    output logic                              busy_o
);

    localparam int OW = $clog2(NUM_MASTERS);
    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam logic [WW-1:0] WD_LIM = WW'(TIMEOUT - 1);
    localparam logic [WW-1:0] WD_MAX = '1;

    typedef enum logic [1:0] {IDLE, OWN, TMO} state_t;

    state_t                   state_q, state_d;
    logic [OW-1:0]            owner_q, owner_d;
    logic [OW-1:0]            last_q, last_d;
    logic [NUM_MASTERS-1:0]   grant_q, grant_d;
    logic [WW-1:0]            wdog_q, wdog_d;
    logic [OW-1:0]            pick;

    // per-master views of the packed buses
    logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] addr_a;
    logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] data_a;
    logic [NUM_MASTERS-1:0][SEL_WIDTH-1:0]  sel_a;
    logic [NUM_MASTERS-1:0][2:0]            cti_a;

    assign addr_a = m_addr_i;
    assign data_a = m_data_i;
    assign sel_a  = m_sel_i;
    assign cti_a  = m_cti_i;

    logic own_cyc, own_stb, own_st, wd_run;

    assign own_cyc = m_cyc_i[owner_q];
    assign own_stb = m_stb_i[owner_q];
    assign own_st  = (state_q == OWN);
    // strobe outstanding with no slave response this cycle
    assign wd_run  = own_st && own_cyc && own_stb && !s_ack_i && !s_err_i;

    // Round-robin pick: scan downward so the final overwrite is the
    // nearest requester above last_q (wrapping).
    always_comb begin
        int idx;
        idx  = 0;
        pick = last_q;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            idx = (int'(last_q) + i) % NUM_MASTERS;
            if (m_cyc_i[idx[OW-1:0]]) pick = idx[OW-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OW'(NUM_MASTERS - 1);   // master 0 wins first
            grant_q <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            wdog_q  <= wdog_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        grant_d = grant_q;
        wdog_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (|m_cyc_i) begin
                    state_d       = OWN;
                    owner_d       = pick;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                end
            end
            OWN: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = owner_q;
                end else if (wd_run && wdog_q == WD_LIM) begin
                    // an ack on this same cycle would have cleared wd_run
                    state_d = TMO;
                end else if (wd_run) begin
                    wdog_d = (wdog_q == WD_MAX) ? wdog_q : wdog_q + 1'b1;
                end
            end
            TMO: begin
                if (own_cyc) begin
                    state_d = OWN;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = owner_q;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Slave side follows the owner's live inputs only while in OWN, so a
    // CYC drop is visible the same cycle and TMO/IDLE drive a quiet bus.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_data_o = '0;
        s_sel_o  = '0;
        s_cti_o  = '0;
        if (own_st) begin
            s_cyc_o  = own_cyc;
            s_stb_o  = own_stb;
            s_we_o   = m_we_i[owner_q];
            s_addr_o = addr_a[owner_q];
            s_data_o = data_a[owner_q];
            s_sel_o  = sel_a[owner_q];
            s_cti_o  = cti_a[owner_q];
        end
    end

    for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_resp
        assign m_ack_o[k] = own_st && grant_q[k] && s_ack_i;
        assign m_err_o[k] = grant_q[k] && ((own_st && s_err_i) || state_q == TMO);
    end

    assign m_data_o = s_data_i;
    assign grant_o  = grant_q;
    assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_wishbone_arbiter.sv
module tb_wishbone_arbiter;
    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NM-1:0]         cyc, stb, we;
    logic [NM-1:0][AW-1:0] addr;
    logic [NM-1:0][DW-1:0] wdat;
    logic [NM-1:0][SW-1:0] sel;
    logic [NM-1:0][2:0]    cti;
    logic [DW-1:0]         m_rdat, s_wdat, s_rdat;
    logic [NM-1:0]         m_ack, m_err, grant;
    logic                  s_cyc, s_stb, s_we, s_ack, s_err, busy;
    logic [AW-1:0]         s_addr;
    logic [SW-1:0]         s_sel;
    logic [2:0]            s_cti;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wishbone_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                       .SEL_WIDTH(SW), .TIMEOUT(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we),
        .m_addr_i(addr), .m_data_i(wdat), .m_sel_i(sel), .m_cti_i(cti),
        .m_data_o(m_rdat), .m_ack_o(m_ack), .m_err_o(m_err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_addr_o(s_addr), .s_data_o(s_wdat), .s_sel_o(s_sel), .s_cti_o(s_cti),
        .s_data_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err),
        .grant_o(grant), .busy_o(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc = '0; stb = '0; we = '0; addr = '0; wdat = '0; sel = '0; cti = '0;
        s_ack = 1'b0; s_err = 1'b0; s_rdat = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [NM-1:0] gseq[$];
        int errs[$];
        bit drop[NM];
        logic [NM-1:0] prev;
        int gap, nerr;

        // ---- reset state
        do_reset();
        rst = 1'b1;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_scyc", s_cyc, 0);
        chk("rst_sstb", s_stb, 0);
        do_reset();

        // ---- single write from master 2
        cyc[2] = 1; stb[2] = 1; we[2] = 1; addr[2] = 32'h10;
        wdat[2] = 32'hDEAD_BEEF; sel[2] = 4'hF;
        @(negedge clk);
        chk("req_grant", grant, 0);
        chk("req_scyc", s_cyc, 0);
        step();
        s_ack = 1; s_rdat = 32'h1234_5678;
        @(negedge clk);
        chk("m2_grant", grant, 4'b0100);
        chk("m2_addr", s_addr, 32'h10);
        chk("m2_data", s_wdat, 32'hDEAD_BEEF);
        chk("m2_we", s_we, 1);
        chk("m2_ack", m_ack, 4'b0100);
        chk("m2_rdat", m_rdat, 32'h1234_5678);
        step();
        s_ack = 0; cyc[2] = 0; stb[2] = 0;
        @(negedge clk);
        chk("m2_drop_scyc", s_cyc, 0);
        chk("m2_drop_busy", busy, 1);
        step();
        @(negedge clk);
        chk("m2_idle_grant", grant, 0);
        chk("m2_idle_busy", busy, 0);

        // ---- round robin among 0,1,3
        do_reset();
        for (int k = 0; k < NM; k++) begin
            drop[k] = 0;
            addr[k] = 32'h1000 * (k + 1);
        end
        cyc = 4'b1011; stb = 4'b1011;
        prev = '0; gap = 0;
        for (int c = 0; c < 40 && gseq.size() < 6; c++) begin
            @(negedge clk);
            if (grant != 0 && prev == 0) begin
                if (gseq.size() > 0) chk("rr_gap", gap, 1);
                gseq.push_back(grant);
                gap = 0;
            end else if (grant == 0) begin
                gap++;
            end
            prev = grant;
            step();
            s_ack = 0;
            for (int k = 0; k < NM; k++) begin
                if (k != 2) begin
                    if (drop[k]) begin cyc[k] = 0; stb[k] = 0; drop[k] = 0; end
                    else begin cyc[k] = 1; stb[k] = 1; end
                end
            end
            for (int k = 0; k < NM; k++)
                if (grant[k] && cyc[k]) begin s_ack = 1; drop[k] = 1; end
        end
        chk("rr_count", gseq.size(), 6);
        for (int i = 0; i < gseq.size(); i++) begin
            logic [NM-1:0] exp_g;
            case (i % 3)
                0: exp_g = 4'b0001;
                1: exp_g = 4'b0010;
                default: exp_g = 4'b1000;
            endcase
            chk($sformatf("rr_order%0d", i), gseq[i], exp_g);
        end

        // ---- burst from master 1 while master 0 waits
        do_reset();
        cyc[1] = 1; stb[1] = 1; cti[1] = 3'b010; addr[1] = 32'h100;
        addr[0] = 32'h200;
        step();
        cyc[0] = 1; stb[0] = 1;
        for (int b = 0; b < 4; b++) begin
            cti[1] = (b == 3) ? 3'b111 : 3'b010;
            addr[1] = 32'h100 + 4 * b;
            s_ack = 1;
            @(negedge clk);
            chk($sformatf("burst_grant%0d", b), grant, 4'b0010);
            chk($sformatf("burst_ack%0d", b), m_ack, 4'b0010);
            chk($sformatf("burst_cti%0d", b), s_cti, (b == 3) ? 3'b111 : 3'b010);
            chk($sformatf("burst_addr%0d", b), s_addr, 32'h100 + 4 * b);
            step();
        end
        cyc[1] = 0; stb[1] = 0; s_ack = 0;
        @(negedge clk);
        chk("burst_end_scyc", s_cyc, 0);
        step();
        @(negedge clk);
        chk("burst_idle", grant, 0);
        step();
        @(negedge clk);
        chk("burst_next_grant", grant, 4'b0001);
        chk("burst_next_addr", s_addr, 32'h200);

        // ---- watchdog, slave never answers
        do_reset();
        cyc[0] = 1; stb[0] = 1; addr[0] = 32'h40;
        @(posedge clk);                       // cycle 0: owned, STB seen
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            if (m_err != 0) begin
                errs.push_back(c);
                if (c == 16) begin
                    chk("tmo_err_bits", m_err, 4'b0001);
                    chk("tmo_sstb", s_stb, 0);
                    chk("tmo_ack", m_ack, 0);
                    chk("tmo_busy", busy, 1);
                end
            end
            @(posedge clk);
        end
        chk("tmo_npulse", errs.size(), 2);
        chk("tmo_first", (errs.size() > 0) ? errs[0] : -1, 16);
        chk("tmo_second", (errs.size() > 1) ? errs[1] : -1, 33);

        // ---- ack on the 16th cycle beats the watchdog
        do_reset();
        cyc[0] = 1; stb[0] = 1;
        step();
        nerr = 0;
        for (int c = 0; c < 17; c++) begin
            s_ack = (c == 15);
            @(negedge clk);
            if (m_err != 0) nerr++;
            if (c == 15) chk("late_ack", m_ack, 4'b0001);
            step();
        end
        chk("late_no_err", nerr, 0);
        s_ack = 0;

        // ---- reset in the middle of a burst from master 3
        do_reset();
        cyc[3] = 1; stb[3] = 1; we[3] = 1; cti[3] = 3'b010; addr[3] = 32'h300;
        step();
        s_ack = 1;
        @(negedge clk);
        chk("mid_pre_ack", m_ack, 4'b1000);
        step();
        #2 rst = 1;
        #1;
        chk("mid_grant", grant, 0);
        chk("mid_busy", busy, 0);
        chk("mid_scyc", s_cyc, 0);
        chk("mid_sstb", s_stb, 0);
        chk("mid_addr", s_addr, 0);
        chk("mid_cti", s_cti, 0);
        chk("mid_mack", m_ack, 0);
        cyc[0] = 1; stb[0] = 1;
        step();
        rst = 0; s_ack = 0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_grant", grant, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got running want finished");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/wishbone_arbiter.md
Name: wishbone_arbiter

Overview:
- Round-robin arbiter that shares one Wishbone slave-side bus among NUM_MASTERS master_wishbone instances.
- It sits between the masters and the address decoder / slave interconnect.
- Grants the bus per cycle (CYC) and holds the grant for the whole transaction, including CTI bursts.
- A watchdog terminates transfers the slave never acknowledges, answering the owner with ERR.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..8)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
SEL_WIDTH, DATA_WIDTH/8, byte-select width
TIMEOUT, 16, cycles of unacknowledged STB before the watchdog fires (>=2)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
m_cyc_i  in  NUM_MASTERS  per-master bus request / cycle
m_stb_i  in  NUM_MASTERS  per-master strobe
m_we_i  in  NUM_MASTERS  per-master write enable
m_addr_i  in  NUM_MASTERS*ADDR_WIDTH  packed addresses, master k at [k*ADDR_WIDTH +: ADDR_WIDTH]
m_data_i  in  NUM_MASTERS*DATA_WIDTH  packed write data
m_sel_i  in  NUM_MASTERS*SEL_WIDTH  packed byte selects
m_cti_i  in  NUM_MASTERS*3  packed cycle type identifiers
m_data_o  out  DATA_WIDTH  read data broadcast to all masters
m_ack_o  out  NUM_MASTERS  per-master acknowledge
m_err_o  out  NUM_MASTERS  per-master error
s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side controls
s_addr_o  out  ADDR_WIDTH  slave-side address
s_data_o  out  DATA_WIDTH  slave-side write data
s_sel_o  out  SEL_WIDTH  slave-side byte select
s_cti_o  out  3  slave-side CTI
s_data_i  in  DATA_WIDTH  slave read data
s_ack_i  in  1  slave acknowledge
s_err_i  in  1  slave error
grant_o  out  NUM_MASTERS  one-hot registered grant
busy_o  out  1  high while any master owns the bus

Behaviour:
- Reset (async, any time, including mid-burst):
  - state=IDLE, grant_o=0, busy_o=0, watchdog=0.
  - Priority pointer set so master 0 wins first.
  - All s_* outputs, m_ack_o and m_err_o read 0 immediately.
  - m_data_o is always a direct pass-through of s_data_i, so it has no reset value of its own.
- States: IDLE, OWN, TMO.
- IDLE:
  - If any m_cyc_i is high, pick the first requester searching upward (with wrap) from last_owner+1.
  - Register it into grant_o and go to OWN.
  - Latency: 1 clock from CYC to grant; no slave signal is driven in the request cycle.
- OWN:
  - s_cyc/stb/we/addr/data/sel/cti are combinational muxes of the owner's inputs.
  - m_ack_o[owner]=s_ack_i and m_err_o[owner]=s_err_i; non-owners see 0.
  - Non-owners' requests are ignored (no preemption).
  - Grant is held across CTI 001/010 bursts, STB gaps and the CTI 111 end beat, as long as m_cyc_i[owner]=1.
  - When m_cyc_i[owner]=0: next state IDLE, grant_o=0, last_owner=owner. That cycle s_cyc_o=0 already, because the mux follows the live CYC.
  - One dead cycle in IDLE before the next grant.
- Watchdog:
  - Counter increments each OWN cycle with s_stb_o=1 and s_ack_i=0 and s_err_i=0.
  - Clears on ack, on err, when STB=0, and on leaving OWN.
  - Saturating; width is clog2(TIMEOUT)+1.
  - When the count reaches TIMEOUT-1 while still unacknowledged, go to TMO.
- TMO (exactly 1 cycle):
  - s_stb_o=0, s_cyc_o=0, m_err_o[owner]=1, m_ack_o=0.
  - Next state: OWN if the owner's CYC is still high, else IDLE.
- Simultaneous events:
  - s_ack_i and s_err_i both high: pass both; the master resolves.
  - Ack in the same cycle the count reaches its limit: the ack wins, no TMO.
  - Owner drops CYC the same cycle another master raises it: the new grant follows the IDLE rules next cycle.
- Fairness: any continuously requesting master is granted within NUM_MASTERS-1 other tenures.
- busy_o = (state != IDLE).

Test Plan:
- Reset, then only master 2 raises CYC/STB, write addr 0x0000_0010, data 0xDEAD_BEEF -> grant_o=4'b0100 one cycle later; s_addr_o=0x10, s_data_o=0xDEADBEEF; slave ack reaches m_ack_o[2] only.
- Masters 0,1,3 all hold CYC for repeated single transfers -> grant order 0,1,3,0,1,3; exactly one IDLE cycle between tenures.
- Master 1 runs a 4-beat CTI 010 burst ending with 111 while master 0 requests -> master 1 keeps the grant for all 4 acks; master 0 is granted only after master 1 drops CYC.
- Slave never acks, TIMEOUT=16 -> exactly one m_err_o[owner] pulse, with s_stb_o low that cycle, 16 cycles after STB rise; the counter then restarts.
- Ack arrives on the 16th cycle -> no error, normal ack.
- Assert rst_i mid-burst of master 3 -> grant_o, busy_o and all s_* outputs are 0 the same cycle; after release, requests from 0 and 3 grant master 0 first.
